// File: rtl/ecliptic_fpu_pkg.sv
// rtl/ecliptic_fpu_pkg.sv - shared FP bit-op encodings
package ecliptic_fpu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OP_SGNJ  = 2'b00,
        OP_SGNJN = 2'b01,
        OP_SGNJX = 2'b10,
        OP_PASS  = 2'b11
    } bitop_op_e;

endpackage

// File: rtl/ecliptic_sync_fifo.sv
// rtl/ecliptic_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module ecliptic_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign rd_en    = pop & ~empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign wr_en    = push & (~full | rd_en);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/ecliptic_bitop_arbiter.sv
// rtl/ecliptic_bitop_arbiter.sv - round-robin, credit-protected sharing of the FP bit-op unit
module ecliptic_bitop_arbiter
    import ecliptic_fpu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_src1,
    input  logic [NUM_REQ*DATA_W-1:0]  req_src2,
    input  logic [NUM_REQ*2-1:0]       req_op,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       unit_req,
    output logic [DATA_W-1:0]          unit_src1,
    output logic [DATA_W-1:0]          unit_src2,
    output logic [1:0]                 unit_op,
    input  logic [DATA_W-1:0]          unit_res,
    input  logic                       unit_ack,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_res,
    output logic [ID_W-1:0]            rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       busy,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } idq_entry_t;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [ID_W-1:0]   id;
        logic [TAG_W-1:0]  tag;
    } bitop_rsp_t;

    logic [CW-1:0]   credits;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            can_issue;
    logic            hs;
    logic            rsp_hs;
    int              scan_idx;

    idq_entry_t idq_in, idq_head;
    bitop_rsp_t rsp_in, rsp_head;
    logic       idq_empty, rsp_empty, retire;
    logic       idq_full_unused, rsp_full_unused;
    logic [CW-1:0] idq_count_unused, rsp_count_unused;

    // Credits are registered, so a pop while full frees issue only next cycle
    assign can_issue = (credits < CW'(DEPTH));
    assign hs        = grant_found & can_issue;
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign busy      = (credits != '0);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready            = '0;
        req_ready[grant_idx] = grant_found & can_issue;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            unit_req  <= 1'b0;
            unit_src1 <= '0;
            unit_src2 <= '0;
            unit_op   <= '0;
            rr_ptr    <= '0;
            credits   <= '0;
            err       <= 1'b0;
        end else begin
            unit_req <= hs;
            if (hs) begin
                unit_src1 <= req_src1[DATA_W*grant_idx +: DATA_W];
                unit_src2 <= req_src2[DATA_W*grant_idx +: DATA_W];
                unit_op   <= req_op[2*grant_idx +: 2];
                rr_ptr    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            credits <= credits + CW'(hs) - CW'(rsp_hs);
            if (unit_ack && idq_empty) begin
                err <= 1'b1;
            end
        end
    end

    assign idq_in.id  = grant_idx;
    assign idq_in.tag = req_tag[TAG_W*grant_idx +: TAG_W];
    assign retire     = unit_ack & ~idq_empty;

    ecliptic_sync_fifo #(.WIDTH($bits(idq_entry_t)), .DEPTH(DEPTH)) u_id_queue (
        .clk       (clk),
        .nrst      (nrst),
        .push      (hs),
        .push_data (idq_in),
        .pop       (retire),
        .pop_data  (idq_head),
        .full      (idq_full_unused),
        .empty     (idq_empty),
        .count     (idq_count_unused)
    );

    assign rsp_in.res = unit_res;
    assign rsp_in.id  = idq_head.id;
    assign rsp_in.tag = idq_head.tag;

    ecliptic_sync_fifo #(.WIDTH($bits(bitop_rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (retire),
        .push_data (rsp_in),
        .pop       (rsp_hs),
        .pop_data  (rsp_head),
        .full      (rsp_full_unused),
        .empty     (rsp_empty),
        .count     (rsp_count_unused)
    );

    assign rsp_valid = ~rsp_empty;
    assign rsp_res   = rsp_head.res;
    assign rsp_id    = rsp_head.id;
    assign rsp_tag   = rsp_head.tag;

endmodule

// File: tb/tb_ecliptic_bitop_arbiter.sv
// tb/tb_ecliptic_bitop_arbiter.sv - directed self-checking bench for ecliptic_bitop_arbiter
module tb_ecliptic_bitop_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic [3:0]  req_op;
    logic [7:0]  req_tag;
    logic        unit_req;
    logic [31:0] unit_src1;
    logic [31:0] unit_src2;
    logic [1:0]  unit_op;
    logic [31:0] unit_res;
    logic        unit_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic [0:0]  rsp_id;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic        err;

    logic        model_ack;
    logic [31:0] model_res;
    logic        spur_ack;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [0:0]  id;
        logic [3:0]  tag;
    } rsp_rec_t;

    int       gq[$];
    rsp_rec_t rq[$];

    always #5 clk = ~clk;

    ecliptic_bitop_arbiter dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .req_op    (req_op),
        .req_tag   (req_tag),
        .unit_req  (unit_req),
        .unit_src1 (unit_src1),
        .unit_src2 (unit_src2),
        .unit_op   (unit_op),
        .unit_res  (unit_res),
        .unit_ack  (unit_ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .busy      (busy),
        .err       (err)
    );

    function automatic logic [31:0] bitop(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return {b[31], a[30:0]};
            2'b01:   return {~b[31], a[30:0]};
            2'b10:   return {a[31] ^ b[31], a[30:0]};
            default: return a;
        endcase
    endfunction

    // Bit-op unit: result and ack one cycle after each request, shares nrst
    always @(posedge clk) begin
        if (!nrst) begin
            model_ack <= 1'b0;
            model_res <= '0;
        end else begin
            model_ack <= unit_req;
            model_res <= bitop(unit_src1, unit_src2, unit_op);
        end
    end
    assign unit_ack = model_ack | spur_ack;
    assign unit_res = model_res;

    always @(posedge clk) begin
        if (nrst) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) gq.push_back(i);
            end
            if (rsp_valid && rsp_ready) rq.push_back({rsp_res, rsp_id, rsp_tag});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [1:0] op, input logic [3:0] tag);
        req_src1[32*i +: 32] = s1;
        req_src2[32*i +: 32] = s2;
        req_op[2*i +: 2]     = op;
        req_tag[4*i +: 4]    = tag;
    endtask

    task automatic chk_rsp(input string name, input int n, input logic [0:0] id,
                           input logic [3:0] tag, input logic [31:0] res);
        rsp_rec_t got;
        got = (n < rq.size()) ? rq[n] : '1;
        chk({name, "_id"}, got.id, id);
        chk({name, "_tag"}, got.tag, tag);
        chk({name, "_res"}, got.res, res);
    endtask

    task automatic chk_grant(input string name, input int n, input int exp);
        chk(name, (n < gq.size()) ? gq[n] : -1, exp);
    endtask

    initial begin
        nrst = 1'b0; req_valid = '0; req_src1 = '0; req_src2 = '0; req_op = '0; req_tag = '0;
        rsp_ready = 1'b0; spur_ack = 1'b0;
        step(2);
        chk("rst_unit_req", unit_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_unit_src1", unit_src1, 0);
        nrst = 1'b1;
        step(1);

        // Single op: sgnj 1.0 with -0 sign gives -1.0
        set_req(0, 32'h3F800000, 32'h80000000, 2'b00, 4'd5);
        req_valid = 2'b01;
        #1 chk("single_ready", req_ready, 2'b01);
        step(1);
        req_valid = 2'b00;
        chk("single_unit_req", unit_req, 1);
        chk("single_unit_src1", unit_src1, 32'h3F800000);
        chk("single_unit_src2", unit_src2, 32'h80000000);
        chk("single_busy", busy, 1);
        chk("single_rsp_early", rsp_valid, 0);
        step(1);
        chk("single_unit_req_drop", unit_req, 0);
        chk("single_rsp_early2", rsp_valid, 0);
        step(1);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_res", rsp_res, 32'hBF800000);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_rsp_tag", rsp_tag, 5);
        rsp_ready = 1'b1;
        step(1);
        chk("single_drained", rsp_valid, 0);
        chk("single_idle", busy, 0);

        // Fairness, RR pointer now at 1
        gq.delete(); rq.delete();
        set_req(0, 32'hBF800000, 32'h80000000, 2'b10, 4'd1);
        set_req(1, 32'h40000000, 32'h00000000, 2'b01, 4'd2);
        req_valid = 2'b11;
        #1 chk("fair_first_ready", req_ready, 2'b10);
        step(4);
        req_valid = 2'b00;
        step(5);
        set_req(0, 32'h12345678, 32'h00000000, 2'b11, 4'd3);
        set_req(1, 32'h7F000000, 32'h80000000, 2'b00, 4'd4);
        req_valid = 2'b11;
        step(2);
        req_valid = 2'b00;
        step(5);
        chk("fair_grants", gq.size(), 6);
        chk_grant("fair_g0", 0, 1);
        chk_grant("fair_g1", 1, 0);
        chk_grant("fair_g2", 2, 1);
        chk_grant("fair_g3", 3, 0);
        chk("fair_rsps", rq.size(), 6);
        chk_rsp("fair_r0", 0, 1, 4'd2, 32'hC0000000);
        chk_rsp("fair_r1", 1, 0, 4'd1, 32'h3F800000);
        chk_rsp("fair_r3", 3, 0, 4'd1, 32'h3F800000);
        chk_rsp("fair_r4", 4, 1, 4'd4, 32'hFF000000);
        chk_rsp("fair_r5", 5, 0, 4'd3, 32'h12345678);

        // Backpressure fills all credits
        gq.delete(); rq.delete();
        rsp_ready = 1'b0;
        set_req(0, 32'hA0A0A0A0, 32'h0, 2'b11, 4'd6);
        set_req(1, 32'hB0B0B0B0, 32'h0, 2'b11, 4'd7);
        req_valid = 2'b11;
        step(6);
        chk("bp_grants", gq.size(), 4);
        chk("bp_ready_full", req_ready, 2'b00);
        chk("bp_busy", busy, 1);
        chk("bp_head_valid", rsp_valid, 1);
        chk("bp_head_id", rsp_id, 1);
        chk("bp_head_res", rsp_res, 32'hB0B0B0B0);
        rsp_ready = 1'b1;
        #1 chk("bp_full_with_pop", req_ready, 2'b00);
        step(1);
        chk("bp_no_issue_at_full", gq.size(), 4);
        req_valid = 2'b00;
        step(1);
        // Credits at 2: handshake and pop on the same edge
        set_req(0, 32'hC0C0C0C0, 32'h0, 2'b11, 4'd8);
        req_valid = 2'b01;
        #1 chk("sim_ready", req_ready, 2'b01);
        step(1);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        step(4);
        set_req(0, 32'hD0D0D0D0, 32'h0, 2'b11, 4'd9);
        req_valid = 2'b11;
        step(4);
        chk("sim_two_credits_left", gq.size(), 7);
        chk("sim_ready_full", req_ready, 2'b00);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step(10);
        chk_grant("sim_g4", 4, 0);
        chk_grant("sim_g5", 5, 1);
        chk_grant("sim_g6", 6, 0);
        chk("bp_rsps", rq.size(), 7);
        chk_rsp("bp_r0", 0, 1, 4'd7, 32'hB0B0B0B0);
        chk_rsp("bp_r1", 1, 0, 4'd6, 32'hA0A0A0A0);
        chk_rsp("bp_r4", 4, 0, 4'd8, 32'hC0C0C0C0);
        chk_rsp("bp_r5", 5, 1, 4'd7, 32'hB0B0B0B0);
        chk_rsp("bp_r6", 6, 0, 4'd9, 32'hD0D0D0D0);
        chk("bp_idle", busy, 0);
        chk("bp_empty", rsp_valid, 0);

        // Spurious ack with nothing in flight
        spur_ack = 1'b1;
        step(1);
        spur_ack = 1'b0;
        chk("spur_err", err, 1);
        chk("spur_no_rsp", rsp_valid, 0);
        chk("spur_no_credit", busy, 0);
        step(3);
        chk("spur_err_sticky", err, 1);
        chk("spur_no_rsp_late", rsp_valid, 0);

        // Reset with three operations outstanding
        rsp_ready = 1'b0;
        set_req(0, 32'h11111111, 32'h0, 2'b11, 4'd1);
        req_valid = 2'b01;
        step(3);
        req_valid = 2'b00;
        chk("rstmid_busy", busy, 1);
        nrst = 1'b0;
        step(1);
        nrst = 1'b1;
        chk("rstmid_unit_req", unit_req, 0);
        chk("rstmid_unit_src1", unit_src1, 0);
        chk("rstmid_unit_src2", unit_src2, 0);
        chk("rstmid_unit_op", unit_op, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_err", err, 0);
        chk("rstmid_busy_clr", busy, 0);
        step(3);
        chk("rstmid_rsp_quiet", rsp_valid, 0);
        set_req(1, 32'h3F800000, 32'h3F800000, 2'b01, 4'hA);
        req_valid = 2'b10;
        #1 chk("fresh_ready", req_ready, 2'b10);
        step(1);
        req_valid = 2'b00;
        step(2);
        chk("fresh_rsp_valid", rsp_valid, 1);
        chk("fresh_rsp_res", rsp_res, 32'hBF800000);
        chk("fresh_rsp_id", rsp_id, 1);
        chk("fresh_rsp_tag", rsp_tag, 4'hA);
        rsp_ready = 1'b1;
        step(1);
        chk("fresh_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
